// File: rtl/uart_rx_param_if.sv
// Receive-side handshake bundle: head-of-FIFO data and status flags, plus the consumer's ready.
interface uart_rx_param_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_error;
    logic       frame_error;
    logic       break_det;

    modport master (output rx_data, rx_valid, parity_error, frame_error, break_det,
                    input  rx_ready);
    modport slave  (input  rx_data, rx_valid, parity_error, frame_error, break_det,
                    output rx_ready);
endinterface

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with runtime frame format and a small receive FIFO carrying
// per-entry parity/frame/break status.
module uart_rx_param #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx,
    input  logic [1:0]             cfg_data_bits,
    input  logic                   cfg_parity_en,
    input  logic                   cfg_parity_odd,
    input  logic                   cfg_stop2,
    uart_rx_param_if.master        rxo,
    output logic                   overrun
);
    localparam int unsigned DIV_RAW = (CLK_FREQ_HZ + BAUD_RATE * OVERSAMPLE / 2) /
                                      (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIVISOR = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int unsigned CNT_W   = $clog2(OVERSAMPLE + 2);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT
    } state_e;

    // ---------------- synchroniser and sample tick ----------------
    logic [1:0]       sync_q;
    logic             rx_s;
    logic [DIV_W-1:0] div_q;
    logic             tick;

    assign rx_s = sync_q[1];
    assign tick = (div_q == DIV_W'(DIVISOR - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            div_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], rx};
            div_q  <= tick ? '0 : div_q + 1'b1;
        end
    end

    // ---------------- receive FSM ----------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       samp_q, samp_d;
    logic [2:0]       last_q, last_d;
    logic             par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
    logic             par_bit_q, par_bit_d, perr_q, perr_d, ferr_q, ferr_d;
    logic             bit_val, push;
    logic [10:0]      push_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            samp_q    <= '0;
            last_q    <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            par_bit_q <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            samp_q    <= samp_d;
            last_q    <= last_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            stop2_q   <= stop2_d;
            par_bit_q <= par_bit_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        data_d     = data_q;
        samp_d     = samp_q;
        last_d     = last_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        stop2_d    = stop2_q;
        par_bit_d  = par_bit_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        push       = 1'b0;
        push_entry = '0;
        cnt_inc    = cnt_q + 1'b1;
        bit_val    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d = S_START;
                        cnt_d   = CNT_W'(1);
                    end
                end
                S_START: begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_W'(OVERSAMPLE / 2)) begin
                        // Mid-start point: bit timing is measured from here on.
                        state_d   = S_DATA;
                        cnt_d     = '0;
                        bit_d     = '0;
                        data_d    = '0;
                        par_bit_d = 1'b0;
                        perr_d    = 1'b0;
                        ferr_d    = 1'b0;
                        last_d    = {1'b1, cfg_data_bits};
                        par_en_d  = cfg_parity_en;
                        par_odd_d = cfg_parity_odd;
                        stop2_d   = cfg_stop2;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_DATA, S_PARITY, S_STOP: begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(OVERSAMPLE - 1)) samp_d[0] = rx_s;
                    if (cnt_inc == CNT_W'(OVERSAMPLE))     samp_d[1] = rx_s;
                    if (cnt_inc == CNT_W'(OVERSAMPLE + 1)) begin
                        // Third sample is one tick past mid-bit, so next bit starts at count 1.
                        cnt_d = CNT_W'(1);
                        if (state_q == S_DATA) begin
                            data_d[bit_q] = bit_val;
                            if (bit_q == last_q) begin
                                bit_d   = '0;
                                state_d = par_en_q ? S_PARITY : S_STOP;
                            end else begin
                                bit_d = bit_q + 1'b1;
                            end
                        end else if (state_q == S_PARITY) begin
                            par_bit_d = bit_val;
                            perr_d    = ((^data_q) ^ bit_val) != par_odd_q;
                            state_d   = S_STOP;
                        end else if (!bit_val && bit_q == '0 && data_q == '0 && !par_bit_q) begin
                            push       = 1'b1;
                            push_entry = {1'b1, 1'b1, perr_q, data_q};
                            state_d    = S_BREAK_WAIT;
                            cnt_d      = '0;
                        end else if (stop2_q && bit_q == '0) begin
                            ferr_d = !bit_val;
                            bit_d  = 3'd1;
                        end else begin
                            push       = 1'b1;
                            push_entry = {1'b0, ferr_q | !bit_val, perr_q, data_q};
                            state_d    = S_IDLE;
                            cnt_d      = '0;
                            bit_d      = '0;
                        end
                    end
                end
                S_BREAK_WAIT: begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- receive FIFO ----------------
    logic [10:0]    mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_q, rd_q;
    logic           empty, full, pop, wr_en, overrun_q;
    logic [10:0]    head;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    assign pop   = !empty && rxo.rx_ready;
    // When full, a simultaneous pop frees the very slot being written.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q      <= '0;
            rd_q      <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (pop)   rd_q <= rd_q + 1'b1;
            overrun_q <= push && full && !pop;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_q[PTR_W-1:0]] <= push_entry;
    end

    assign head              = empty ? '0 : mem[rd_q[PTR_W-1:0]];
    assign rxo.rx_data       = head[7:0];
    assign rxo.parity_error  = head[8];
    assign rxo.frame_error   = head[9];
    assign rxo.break_det     = head[10];
    assign rxo.rx_valid      = !empty;
    assign overrun           = overrun_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 7.3728 MHz clock at 115200 baud gives 4 clocks per tick,
// 64 clocks per bit.
module tb_uart_rx_param;
    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [1:0] cfg_data_bits = 2'b11;
    logic       cfg_parity_en = 1'b0;
    logic       cfg_parity_odd = 1'b0;
    logic       cfg_stop2 = 1'b0;
    logic       overrun;
    int         n_cmp = 0;
    int         n_err = 0;
    int         ovr_cnt = 0;
    int         base;
    bit         found;

    uart_rx_param_if rif ();

    uart_rx_param #(
        .CLK_FREQ_HZ(7_372_800),
        .BAUD_RATE  (115200),
        .OVERSAMPLE (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity_en (cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd),
        .cfg_stop2     (cfg_stop2),
        .rxo           (rif),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (overrun) ovr_cnt <= ovr_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // glitch_bit >= 0 inverts that data bit for 4 clocks (one tick) around its middle.
    task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                              input bit par_bit, input int nstop, input int glitch_bit);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx = d[i];
            if (i == glitch_bit) begin
                repeat (30) @(negedge clk);
                rx = ~d[i];
                repeat (4) @(negedge clk);
                rx = d[i];
                repeat (BIT - 34) @(negedge clk);
            end else begin
                repeat (BIT) @(negedge clk);
            end
        end
        if (par_en) begin
            rx = par_bit;
            repeat (BIT) @(negedge clk);
        end
        for (int i = 0; i < nstop; i++) begin
            rx = 1'b1;
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, 32'(rif.rx_valid), 32'd1);
        chk({tag, "_data"}, 32'(rif.rx_data), 32'(exp));
        rif.rx_ready = 1'b1;
        @(negedge clk);
        rif.rx_ready = 1'b0;
    endtask

    task automatic set_8n1();
        cfg_data_bits = 2'b11; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rif.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(rif.rx_valid), 32'd0);
        chk("rst_data", 32'(rif.rx_data), 32'd0);
        chk("rst_flags", {29'd0, rif.break_det, rif.frame_error, rif.parity_error}, 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // 8N1 0xA5
        set_8n1();
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1, -1);
        chk("a5_valid", 32'(rif.rx_valid), 32'd1);
        chk("a5_data", 32'(rif.rx_data), 32'hA5);
        chk("a5_flags", {29'd0, rif.break_det, rif.frame_error, rif.parity_error}, 32'd0);
        rif.rx_ready = 1'b1;
        @(negedge clk);
        rif.rx_ready = 1'b0;
        chk("a5_popped", 32'(rif.rx_valid), 32'd0);

        // 7E2 0x35: four ones, so the correct even parity bit is 0
        cfg_data_bits = 2'b10; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b1;
        send_frame(8'h35, 7, 1'b1, 1'b1, 2, -1);
        chk("p_bad_data", 32'(rif.rx_data), 32'h35);
        chk("p_bad_pe", 32'(rif.parity_error), 32'd1);
        chk("p_bad_fe", 32'(rif.frame_error), 32'd0);
        pop_chk("p_bad_pop", 8'h35);
        fork
            send_frame(8'h35, 7, 1'b1, 1'b0, 2, -1);
            begin
                repeat (3 * BIT) @(negedge clk);
                cfg_parity_odd = 1'b1;
                cfg_data_bits  = 2'b11;
            end
        join
        chk("p_ok_data", 32'(rif.rx_data), 32'h35);
        chk("p_ok_pe", 32'(rif.parity_error), 32'd0);
        pop_chk("p_ok_pop", 8'h35);
        chk("p_ok_empty", 32'(rif.rx_valid), 32'd0);

        // start-bit glitch of 6 ticks, then single-tick glitch mid data bit 3
        set_8n1();
        rx = 1'b0;
        repeat (24) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        chk("glitch_start_valid", 32'(rif.rx_valid), 32'd0);
        chk("glitch_start_state", 32'(dut.state_q), 32'd0);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1, 3);
        chk("glitch_bit_flags", {29'd0, rif.break_det, rif.frame_error, rif.parity_error}, 32'd0);
        pop_chk("glitch_bit", 8'h55);

        // break: 20 bit times low
        rx = 1'b0;
        repeat (12 * BIT) @(negedge clk);
        chk("brk_data", 32'(rif.rx_data), 32'h00);
        chk("brk_bd", 32'(rif.break_det), 32'd1);
        chk("brk_fe", 32'(rif.frame_error), 32'd1);
        pop_chk("brk_pop", 8'h00);
        repeat (8 * BIT) @(negedge clk);
        chk("brk_hold_empty", 32'(rif.rx_valid), 32'd0);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk("brk_release_empty", 32'(rif.rx_valid), 32'd0);

        // overrun on the fifth frame
        base = ovr_cnt;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 8, 1'b0, 1'b0, 1, -1);
        chk("ovr_none_yet", 32'(ovr_cnt - base), 32'd0);
        send_frame(8'h05, 8, 1'b0, 1'b0, 1, -1);
        chk("ovr_pulse", 32'(ovr_cnt - base), 32'd1);
        for (int i = 1; i <= 4; i++) pop_chk("ovr_pop", 8'(i));
        chk("ovr_drained", 32'(rif.rx_valid), 32'd0);

        // full FIFO with pop on the push cycle: no overrun
        base = ovr_cnt;
        for (int i = 1; i <= 4; i++) send_frame(8'(8'h10 + i), 8, 1'b0, 1'b0, 1, -1);
        found = 1'b0;
        fork
            send_frame(8'h15, 8, 1'b0, 1'b0, 1, -1);
            begin
                for (int i = 0; i < 12 * BIT && !found; i++) begin
                    @(negedge clk);
                    if (dut.push) found = 1'b1;
                end
                if (found) begin
                    rif.rx_ready = 1'b1;
                    @(negedge clk);
                    rif.rx_ready = 1'b0;
                end
            end
        join
        chk("pp_push_seen", 32'(found), 32'd1);
        chk("pp_no_ovr", 32'(ovr_cnt - base), 32'd0);
        for (int i = 2; i <= 5; i++) pop_chk("pp_pop", 8'(8'h10 + i));
        chk("pp_drained", 32'(rif.rx_valid), 32'd0);

        // reset during data bit 3 with one entry pending
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1, -1);
        chk("pre_rst_valid", 32'(rif.rx_valid), 32'd1);
        fork
            send_frame(8'hFF, 8, 1'b0, 1'b0, 1, -1);
            begin
                repeat (4 * BIT + 32) @(negedge clk);
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                chk("mid_rst_valid", 32'(rif.rx_valid), 32'd0);
                chk("mid_rst_data", 32'(rif.rx_data), 32'd0);
                chk("mid_rst_flags", {29'd0, rif.break_det, rif.frame_error, rif.parity_error}, 32'd0);
                chk("mid_rst_overrun", 32'(overrun), 32'd0);
                rst_n = 1'b1;
            end
        join
        repeat (2 * BIT) @(negedge clk);
        chk("post_rst_empty", 32'(rif.rx_valid), 32'd0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1, -1);
        chk("post_rst_flags", {29'd0, rif.break_det, rif.frame_error, rif.parity_error}, 32'd0);
        pop_chk("post_rst", 8'h5A);
        chk("post_rst_drained", 32'(rif.rx_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
